// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for a multicycle RV32I datapath: decodes the instruction register,
// sequences fetch/memory/ALU/branch steps and counts retired instructions.
module multicycle_ctrl_fsm #(
    parameter bit TRAP_EN  = 1'b1,
    parameter int CNT_W    = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr_i,
    input  logic                imem_ready_i,
    input  logic                dmem_ready_i,
    input  logic                branch_taken_i,
    output logic [3:0]          state_o,
    output logic                imem_req_o,
    output logic                ir_we_o,
    output logic                pc_we_o,
    output logic [1:0]          pc_src_o,
    output logic                rf_we_o,
    output logic [1:0]          rf_wsel_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          alu_srca_o,
    output logic                alu_srcb_o,
    output logic [2:0]          imm_type_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [2:0]          load_type_o,
    output logic [1:0]          store_type_o,
    output logic                illegal_o,
    output logic                retired_o,
    output logic [CNT_W-1:0]    retire_cnt_o
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
        JUMP = 4'd10, UPPER = 4'd11, TRAP = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    state_t      state, next;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        bad, alt;
    logic [3:0]  alu, alu_func, alu_br;
    logic [2:0]  ld_type;
    logic [1:0]  st_type;
    logic        unused;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign unused = ^{instr_i[24:15], instr_i[11:7]};
    // instr[30] selects SUB/SRA only for R-type or shift-right; for ADDI it is immediate data
    assign alt    = instr_i[30] && (opcode == OP_R || funct3 == 3'b101);

    always_comb begin
        bad = 1'b0;
        case (opcode)
            OP_LOAD:   bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OP_STORE:  bad = funct3 > 3'b010;
            OP_BRANCH: bad = funct3[2:1] == 2'b01;
            OP_JALR:   bad = funct3 != 3'b000;
            OP_R:      bad = !(funct7 == 7'b0000000 ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            OP_I: begin
                if (funct3 == 3'b001)      bad = funct7 != 7'b0000000;
                else if (funct3 == 3'b101) bad = funct7 != 7'b0000000 && funct7 != 7'b0100000;
            end
            OP_JAL, OP_LUI, OP_AUIPC: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
    end

    always_comb begin
        alu_func = 4'd0;
        case (funct3)
            3'b000: alu_func = alt ? 4'd1 : 4'd0;
            3'b001: alu_func = 4'd2;
            3'b010: alu_func = 4'd5;
            3'b011: alu_func = 4'd6;
            3'b100: alu_func = 4'd7;
            3'b101: alu_func = alt ? 4'd4 : 4'd3;
            3'b110: alu_func = 4'd8;
            default: alu_func = 4'd9;
        endcase
        alu_br = 4'd10;
        case (funct3)
            3'b001: alu_br = 4'd11;
            3'b100: alu_br = 4'd12;
            3'b101: alu_br = 4'd13;
            3'b110: alu_br = 4'd14;
            3'b111: alu_br = 4'd15;
            default: alu_br = 4'd10;
        endcase
        ld_type = 3'd0;
        case (funct3)
            3'b000: ld_type = 3'd1;
            3'b001: ld_type = 3'd2;
            3'b010: ld_type = 3'd3;
            3'b100: ld_type = 3'd4;
            3'b101: ld_type = 3'd5;
            default: ld_type = 3'd0;
        endcase
        st_type = (funct3 <= 3'b010) ? funct3[1:0] + 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            retire_cnt_o <= '0;
        end else begin
            state <= next;
            if (retired_o) retire_cnt_o <= retire_cnt_o + CNT_W'(1);
        end
    end

    always_comb begin
        next = state;
        imem_req_o = 1'b0; ir_we_o = 1'b0; pc_we_o = 1'b0; pc_src_o = 2'd0;
        rf_we_o = 1'b0; rf_wsel_o = 2'd0; alu = 4'd0; alu_srca_o = 2'd0;
        alu_srcb_o = 1'b0; imm_type_o = 3'd0; dmem_req_o = 1'b0; dmem_we_o = 1'b0;
        load_type_o = 3'd0; store_type_o = 2'd0; illegal_o = 1'b0; retired_o = 1'b0;
        case (state)
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o = 1'b1; pc_we_o = 1'b1; next = DECODE;
                end
            end
            DECODE: begin
                if (bad) next = TRAP_EN ? TRAP : FETCH;
                else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: next = MEMADDR;
                        OP_R:              next = EXEC_R;
                        OP_I:              next = EXEC_I;
                        OP_BRANCH:         next = BRANCH;
                        OP_JAL, OP_JALR:   next = JUMP;
                        default:           next = UPPER;
                    endcase
                end
            end
            MEMADDR: begin
                alu_srcb_o = 1'b1;
                imm_type_o = (opcode == OP_LOAD) ? 3'd0 : 3'd1;
                next = (opcode == OP_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                dmem_req_o = 1'b1; load_type_o = ld_type;
                if (dmem_ready_i) next = MEMWB;
            end
            MEMWR: begin
                dmem_req_o = 1'b1; dmem_we_o = 1'b1; store_type_o = st_type;
                if (dmem_ready_i) begin
                    retired_o = 1'b1; next = FETCH;
                end
            end
            MEMWB: begin
                rf_we_o = 1'b1; rf_wsel_o = 2'd1; load_type_o = ld_type;
                retired_o = 1'b1; next = FETCH;
            end
            EXEC_R, EXEC_I, ALUWB: begin
                alu = alu_func;
                alu_srcb_o = (opcode == OP_I);
                if (state == ALUWB) begin
                    rf_we_o = 1'b1; retired_o = 1'b1; next = FETCH;
                end else next = ALUWB;
            end
            BRANCH: begin
                alu = alu_br; imm_type_o = 3'd2;
                pc_we_o = branch_taken_i; pc_src_o = 2'd1;
                retired_o = 1'b1; next = FETCH;
            end
            JUMP: begin
                rf_we_o = 1'b1; rf_wsel_o = 2'd2; pc_we_o = 1'b1;
                if (opcode == OP_JAL) begin
                    pc_src_o = 2'd2; imm_type_o = 3'd4;
                end else begin
                    pc_src_o = 2'd3; alu_srcb_o = 1'b1;
                end
                retired_o = 1'b1; next = FETCH;
            end
            UPPER: begin
                imm_type_o = 3'd3; alu_srcb_o = 1'b1;
                alu_srca_o = (opcode == OP_LUI) ? 2'd2 : 2'd1;
                rf_we_o = 1'b1; retired_o = 1'b1; next = FETCH;
            end
            TRAP:    illegal_o = 1'b1;
            default: next = FETCH;
        endcase
        // Outputs are held quiet during reset whatever the current state
        if (!rst_n) begin
            imem_req_o = 1'b0; ir_we_o = 1'b0; pc_we_o = 1'b0; pc_src_o = 2'd0;
            rf_we_o = 1'b0; rf_wsel_o = 2'd0; alu = 4'd0; alu_srca_o = 2'd0;
            alu_srcb_o = 1'b0; imm_type_o = 3'd0; dmem_req_o = 1'b0; dmem_we_o = 1'b0;
            load_type_o = 3'd0; store_type_o = 2'd0; illegal_o = 1'b0; retired_o = 1'b0;
        end
    end

    assign alu_op_o = ALU_OP_W'(alu);
    assign state_o  = state;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: instance a (TRAP_EN=1, 32-bit count) and instance b (TRAP_EN=0,
// 4-bit count) share stimulus; expected values are hand-derived per instruction.
module tb_multicycle_ctrl_fsm;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, taken = 1'b0;

    logic [3:0]  a_state, b_state;
    logic        a_imem_req, a_ir_we, a_pc_we, a_rf_we, a_srcb, a_dmem_req, a_dmem_we, a_ill, a_ret;
    logic        b_imem_req, b_ir_we, b_pc_we, b_rf_we, b_srcb, b_dmem_req, b_dmem_we, b_ill, b_ret;
    logic [1:0]  a_pc_src, a_rf_wsel, a_srca, a_st, b_pc_src, b_rf_wsel, b_srca, b_st;
    logic [4:0]  a_alu, b_alu;
    logic [2:0]  a_imm, a_ld, b_imm, b_ld;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    int n_chk = 0, n_pass = 0;

    localparam logic [31:0] ADDI = 32'h00500093, LW = 32'h0000A103, BEQ = 32'h00000463,
                            SUB = 32'h40208033, SW = 32'h0020A023, JAL = 32'h0000006F,
                            LUI = 32'h000000B7, BAD = 32'hFFFFFFFF;

    multicycle_ctrl_fsm #(.TRAP_EN(1'b1), .CNT_W(32), .ALU_OP_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .imem_ready_i(imem_ready),
        .dmem_ready_i(dmem_ready), .branch_taken_i(taken), .state_o(a_state),
        .imem_req_o(a_imem_req), .ir_we_o(a_ir_we), .pc_we_o(a_pc_we), .pc_src_o(a_pc_src),
        .rf_we_o(a_rf_we), .rf_wsel_o(a_rf_wsel), .alu_op_o(a_alu), .alu_srca_o(a_srca),
        .alu_srcb_o(a_srcb), .imm_type_o(a_imm), .dmem_req_o(a_dmem_req), .dmem_we_o(a_dmem_we),
        .load_type_o(a_ld), .store_type_o(a_st), .illegal_o(a_ill), .retired_o(a_ret),
        .retire_cnt_o(a_cnt));

    multicycle_ctrl_fsm #(.TRAP_EN(1'b0), .CNT_W(4), .ALU_OP_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .imem_ready_i(imem_ready),
        .dmem_ready_i(dmem_ready), .branch_taken_i(taken), .state_o(b_state),
        .imem_req_o(b_imem_req), .ir_we_o(b_ir_we), .pc_we_o(b_pc_we), .pc_src_o(b_pc_src),
        .rf_we_o(b_rf_we), .rf_wsel_o(b_rf_wsel), .alu_op_o(b_alu), .alu_srca_o(b_srca),
        .alu_srcb_o(b_srcb), .imm_type_o(b_imm), .dmem_req_o(b_dmem_req), .dmem_we_o(b_dmem_we),
        .load_type_o(b_ld), .store_type_o(b_st), .illegal_o(b_ill), .retired_o(b_ret),
        .retire_cnt_o(b_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves the FSM in the state following DECODE
    task automatic fetch_decode(input logic [31:0] ins);
        instr = ins; imem_ready = 1'b1; #1;
        chk("fetch_ir_we", a_ir_we, 1);
        tick();
        chk("decode_state", a_state, 1);
        tick();
    endtask

    task automatic do_addi();
        instr = ADDI; imem_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        // reset: outputs gated even though FETCH would request
        imem_ready = 1'b1;
        tick();
        chk("rst_state", a_state, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_imem_req", a_imem_req, 0);
        chk("rst_ir_we", a_ir_we, 0);
        rst_n = 1'b1; imem_ready = 1'b0; #1;
        chk("fetch_req", a_imem_req, 1);
        tick();
        chk("fetch_hold", a_state, 0);
        chk("fetch_hold_ir_we", a_ir_we, 0);

        // ADDI
        instr = ADDI; imem_ready = 1'b1; #1;
        chk("addi_pc_we", a_pc_we, 1);
        chk("addi_pc_src", a_pc_src, 0);
        tick(); chk("addi_decode", a_state, 1);
        tick(); chk("addi_exec_i", a_state, 7); chk("addi_srcb", a_srcb, 1);
        tick(); chk("addi_aluwb", a_state, 8); chk("addi_rf_we", a_rf_we, 1);
        chk("addi_alu", a_alu, 0); chk("addi_ret", a_ret, 1); chk("addi_cnt_pre", a_cnt, 0);
        tick(); chk("addi_fetch", a_state, 0); chk("addi_cnt", a_cnt, 1);

        // LW with three wait cycles
        fetch_decode(LW);
        chk("lw_memaddr", a_state, 2); chk("lw_srcb", a_srcb, 1); chk("lw_imm", a_imm, 0);
        dmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_state", a_state, 3); chk("lw_dmem_req", a_dmem_req, 1);
            chk("lw_dmem_we", a_dmem_we, 0);
            tick();
        end
        dmem_ready = 1'b1; #1;
        chk("lw_memrd4", a_state, 3); chk("lw_ld_rd", a_ld, 3);
        tick(); dmem_ready = 1'b0;
        chk("lw_memwb", a_state, 4); chk("lw_rf_we", a_rf_we, 1); chk("lw_wsel", a_rf_wsel, 1);
        chk("lw_ld", a_ld, 3); chk("lw_ret", a_ret, 1);
        tick(); chk("lw_cnt", a_cnt, 2);

        // BEQ taken then not taken
        fetch_decode(BEQ);
        taken = 1'b1; #1;
        chk("beq_state", a_state, 9); chk("beq_pc_we", a_pc_we, 1); chk("beq_pc_src", a_pc_src, 1);
        chk("beq_alu", a_alu, 10); chk("beq_imm", a_imm, 2); chk("beq_ret", a_ret, 1);
        tick(); taken = 1'b0;
        chk("beq_cnt", a_cnt, 3);
        fetch_decode(BEQ);
        chk("beq_nt_pc_we", a_pc_we, 0); chk("beq_nt_ret", a_ret, 1);
        tick(); chk("beq_nt_cnt", a_cnt, 4);

        // SUB (R-type)
        fetch_decode(SUB);
        chk("sub_exec_r", a_state, 6); chk("sub_alu", a_alu, 1); chk("sub_srcb", a_srcb, 0);
        tick(); chk("sub_aluwb_alu", a_alu, 1); chk("sub_wsel", a_rf_wsel, 0);
        tick(); chk("sub_cnt", a_cnt, 5);

        // SW
        fetch_decode(SW);
        chk("sw_memaddr", a_state, 2); chk("sw_imm", a_imm, 1);
        tick(); dmem_ready = 1'b1; #1;
        chk("sw_memwr", a_state, 5); chk("sw_we", a_dmem_we, 1); chk("sw_st", a_st, 3);
        chk("sw_ret", a_ret, 1);
        tick(); dmem_ready = 1'b0;
        chk("sw_fetch", a_state, 0); chk("sw_cnt", a_cnt, 6);

        // JAL
        fetch_decode(JAL);
        chk("jal_state", a_state, 10); chk("jal_pc_src", a_pc_src, 2); chk("jal_wsel", a_rf_wsel, 2);
        chk("jal_imm", a_imm, 4); chk("jal_pc_we", a_pc_we, 1);
        tick(); chk("jal_cnt", a_cnt, 7);

        // LUI
        fetch_decode(LUI);
        chk("lui_state", a_state, 11); chk("lui_srca", a_srca, 2); chk("lui_imm", a_imm, 3);
        chk("lui_rf_we", a_rf_we, 1);
        tick(); chk("lui_cnt", a_cnt, 8);

        // Illegal instruction: a traps, b discards
        instr = BAD; imem_ready = 1'b1;
        tick();
        chk("bad_decode_ret_a", a_ret, 0); chk("bad_decode_ret_b", b_ret, 0);
        tick();
        chk("bad_b_fetch", b_state, 0);
        for (int i = 0; i < 10; i++) begin
            chk("trap_state", a_state, 12); chk("trap_ill", a_ill, 1); chk("trap_req", a_imem_req, 0);
            tick();
        end
        chk("trap_cnt_a", a_cnt, 8); chk("trap_cnt_b", b_cnt, 8);

        // reset mid MEMRD wait
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        fetch_decode(LW);
        dmem_ready = 1'b0;
        tick(); tick();
        chk("rst_memrd", a_state, 3); chk("rst_memrd_req", a_dmem_req, 1);
        rst_n = 1'b0; #1;
        chk("rst_low_req", a_dmem_req, 0);
        tick(); rst_n = 1'b1; #1;
        chk("rst_fetch", a_state, 0); chk("rst_cnt2", a_cnt, 0); chk("rst_dreq", a_dmem_req, 0);

        // 4-bit counter wrap
        repeat (15) do_addi();
        chk("wrap_15", b_cnt, 15);
        do_addi();
        chk("wrap_0", b_cnt, 0);
        chk("wrap_a16", a_cnt, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
